// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared core types: forwarding-select codes and the in-flight shadow entry.
// Used by the hazard controller, register bank mux and decode.
package pipe_hazard_ctrl_pkg;

    localparam int RW_MAX = 8;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_EX = 2'd1;
    localparam logic [1:0] FWD_DM = 2'd2;
    localparam logic [1:0] FWD_WB = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [RW_MAX-1:0] rw;
        logic              wr_en;
        logic              is_load;
        logic              is_mc;
    } shadow_t;

    function automatic logic shadow_hit(input shadow_t s, input logic [RW_MAX-1:0] src);
        return s.valid && s.wr_en && (s.rw == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the DC stage and the hazard controller.
// Controller outputs are combinational; no handshake, the core consumes them every cycle.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              dc_valid;
    logic [REG_AW-1:0] dc_ra;
    logic [REG_AW-1:0] dc_rb;
    logic              dc_use_a;
    logic              dc_use_b;
    logic [REG_AW-1:0] dc_rw;
    logic              dc_wr_en;
    logic              dc_is_load;
    logic              dc_is_mc;
    logic              ex_branch_taken;
    logic              irq_take;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;
    logic              stall_pc;
    logic              stall_dc;
    logic              bubble_ex;
    logic              flush_dc;
    logic              mc_hold;

    modport master (
        output dc_valid, dc_ra, dc_rb, dc_use_a, dc_use_b, dc_rw, dc_wr_en,
               dc_is_load, dc_is_mc, ex_branch_taken, irq_take,
        input  fwd_sel_a, fwd_sel_b, stall_pc, stall_dc, bubble_ex, flush_dc, mc_hold
    );

    modport slave (
        input  dc_valid, dc_ra, dc_rb, dc_use_a, dc_use_b, dc_rw, dc_wr_en,
               dc_is_load, dc_is_mc, ex_branch_taken, irq_take,
        output fwd_sel_a, fwd_sel_b, stall_pc, stall_dc, bubble_ex, flush_dc, mc_hold
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Operand forwarding select for one source register, priority EX > DM > WB.
// Latency: combinational; backpressure: none, ex_ok masks an EX result that is not ready.
module pipe_fwd_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  shadow_t           ex,
    input  shadow_t           dm,
    input  shadow_t           wb,
    input  logic              ex_ok,
    output logic [1:0]        sel
);
    logic [RW_MAX-1:0] src_x;
    logic              skip;
    logic              unused_bits;

    assign src_x       = RW_MAX'(src);
    assign skip        = !use_src || ((ZERO_REG != 0) && (src == '0));
    assign unused_bits = ^{ex.is_load, ex.is_mc, dm.is_load, dm.is_mc, wb.is_load, wb.is_mc};

    always_comb begin
        sel = FWD_RF;
        if (!skip) begin
            if (ex_ok && shadow_hit(ex, src_x)) begin
                sel = FWD_EX;
            end else if (shadow_hit(dm, src_x)) begin
                sel = FWD_DM;
            end else if (shadow_hit(wb, src_x)) begin
                sel = FWD_WB;
            end
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding control: tracks EX/DM/WB destinations, drives forwarding, stalls, bubbles, flushes.
// Latency: zero-cycle decisions, shadows update on clk; backpressure: stall_pc/stall_dc hold the front end.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int MC_CYCLES = 4,
    parameter int ZERO_REG  = 1
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int CW = $clog2(MC_CYCLES);

    shadow_t       sh_ex;
    shadow_t       sh_dm;
    shadow_t       sh_wb;
    shadow_t       dc_entry;
    logic [CW-1:0] mc_cnt;
    logic          mc_busy;
    logic          flush;
    logic          load_use;
    logic          stall_lu;
    logic [1:0]    sel_a;
    logic [1:0]    sel_b;

    assign mc_busy = (mc_cnt != '0);

    pipe_fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .src(bus.dc_ra), .use_src(bus.dc_use_a), .ex(sh_ex), .dm(sh_dm), .wb(sh_wb),
        .ex_ok(!mc_busy), .sel(sel_a)
    );

    pipe_fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .src(bus.dc_rb), .use_src(bus.dc_use_b), .ex(sh_ex), .dm(sh_dm), .wb(sh_wb),
        .ex_ok(!mc_busy), .sel(sel_b)
    );

    // A held multi-cycle op defers both branch and interrupt redirects.
    assign flush    = (bus.ex_branch_taken || bus.irq_take) && !mc_busy;
    assign load_use = bus.dc_valid && sh_ex.is_load && ((sel_a == FWD_EX) || (sel_b == FWD_EX));
    assign stall_lu = load_use && !flush && !mc_busy;

    always_comb begin
        dc_entry         = '0;
        dc_entry.valid   = bus.dc_valid && !flush;
        dc_entry.rw      = RW_MAX'(bus.dc_rw);
        dc_entry.wr_en   = bus.dc_wr_en;
        dc_entry.is_load = bus.dc_is_load;
        dc_entry.is_mc   = bus.dc_is_mc;
    end

    // Gate with reset so a redirect input cannot leak out while the core is held in reset.
    always_comb begin
        bus.fwd_sel_a = reset ? sel_a : FWD_RF;
        bus.fwd_sel_b = reset ? sel_b : FWD_RF;
        bus.stall_pc  = reset && (mc_busy || stall_lu);
        bus.stall_dc  = reset && (mc_busy || stall_lu);
        bus.bubble_ex = reset && (flush || stall_lu);
        bus.flush_dc  = reset && flush;
        bus.mc_hold   = reset && mc_busy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_ex  <= '0;
            sh_dm  <= '0;
            sh_wb  <= '0;
            mc_cnt <= '0;
        end else if (mc_busy) begin
            sh_dm  <= '0;
            sh_wb  <= sh_dm;
            mc_cnt <= mc_cnt - 1'b1;
        end else if (stall_lu) begin
            sh_ex <= '0;
            sh_dm <= sh_ex;
            sh_wb <= sh_dm;
        end else begin
            sh_ex <= dc_entry;
            sh_dm <= sh_ex;
            sh_wb <= sh_dm;
            if (dc_entry.valid && dc_entry.is_mc) begin
                mc_cnt <= CW'(MC_CYCLES - 1);
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl; a second instance runs with ZERO_REG=0.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] ra, rb;
        logic       ua, ub;
        logic [4:0] rw;
        logic       we, ld, mc, br, irq;
    } stim_t;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] a, b, za, zb;
        logic [4:0] ctl;
    } exp_t;

    // ctl = {stall_pc, stall_dc, bubble_ex, flush_dc, mc_hold}
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] LU   = 5'b11100;
    localparam logic [4:0] FL   = 5'b00110;
    localparam logic [4:0] HD   = 5'b11001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic obs_vld = 1'b0;
    bit   done = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] next_id = 8'd0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(5)) bus0 ();
    pipe_hazard_ctrl_if #(.REG_AW(5)) bus1 ();

    pipe_hazard_ctrl #(.REG_AW(5), .MC_CYCLES(4), .ZERO_REG(1)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );
    pipe_hazard_ctrl #(.REG_AW(5), .MC_CYCLES(4), .ZERO_REG(0)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    function automatic stim_t st(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                                 input logic ua, input logic ub, input logic [4:0] rw,
                                 input logic we, input logic ld, input logic mc,
                                 input logic br, input logic irq);
        stim_t s;
        s.v = v; s.ra = ra; s.rb = rb; s.ua = ua; s.ub = ub; s.rw = rw;
        s.we = we; s.ld = ld; s.mc = mc; s.br = br; s.irq = irq;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus0.dc_valid = s.v;   bus1.dc_valid = s.v;
        bus0.dc_ra = s.ra;     bus1.dc_ra = s.ra;
        bus0.dc_rb = s.rb;     bus1.dc_rb = s.rb;
        bus0.dc_use_a = s.ua;  bus1.dc_use_a = s.ua;
        bus0.dc_use_b = s.ub;  bus1.dc_use_b = s.ub;
        bus0.dc_rw = s.rw;     bus1.dc_rw = s.rw;
        bus0.dc_wr_en = s.we;  bus1.dc_wr_en = s.we;
        bus0.dc_is_load = s.ld; bus1.dc_is_load = s.ld;
        bus0.dc_is_mc = s.mc;  bus1.dc_is_mc = s.mc;
        bus0.ex_branch_taken = s.br; bus1.ex_branch_taken = s.br;
        bus0.irq_take = s.irq; bus1.irq_take = s.irq;
    endtask

    task automatic step(input stim_t s, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] za, input logic [1:0] zb,
                        input logic [4:0] ctl, input bit rst_mid);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        e.id = next_id; e.a = a; e.b = b; e.za = za; e.zb = zb; e.ctl = ctl;
        next_id = next_id + 8'd1;
        exp_q.push_back(e);
        obs_vld = 1'b1;
        if (rst_mid) begin
            #1 reset = 1'b0;
        end
        @(negedge clk);
        #1 obs_vld = 1'b0;
    endtask

    initial begin
        stim_t a;
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(st(1, 3, 0, 1, 0, 3, 1, 0, 0, 0, 0), 0, 0, 0, 0, NONE, 0);  // c0 in reset
        reset = 1'b1;
        step(st(1, 3, 3, 1, 1, 5, 1, 0, 0, 0, 0), 1, 1, 1, 1, NONE, 0);  // c1 EX fwd both
        step(st(1, 5, 3, 1, 1, 6, 1, 0, 0, 0, 0), 1, 2, 1, 2, NONE, 0);
        step(st(1, 3, 5, 1, 1, 4, 1, 1, 0, 0, 0), 3, 2, 3, 2, NONE, 0);
        a = st(1, 4, 4, 0, 1, 7, 1, 0, 0, 0, 0);
        step(a, 0, 1, 0, 1, LU, 0);                                      // c4 load-use on B
        step(a, 0, 2, 0, 2, NONE, 0);
        step(st(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0), 0, 0, 0, 0, NONE, 0);
        a = st(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0);
        step(a, 1, 1, 1, 1, LU, 0);                                      // c7 both operands
        step(a, 2, 2, 2, 2, NONE, 0);
        step(st(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0), 0, 0, 0, 0, NONE, 0);
        step(st(1, 10, 0, 1, 0, 11, 1, 0, 0, 1, 0), 1, 0, 1, 0, FL, 0); // c10 branch masks stall
        step(st(1, 10, 9, 1, 1, 2, 1, 0, 0, 0, 0), 2, 3, 2, 3, NONE, 0);
        step(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 0, NONE, 0); // c12 r0 writes
        step(st(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0), 0, 0, 1, 1, NONE, 0);
        step(st(1, 0, 2, 1, 1, 0, 1, 0, 0, 0, 0), 0, 3, 1, 3, NONE, 0);
        a = st(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step(a, 0, 0, 1, 1, NONE, 0);
        step(a, 0, 0, 2, 2, NONE, 0);
        step(a, 0, 0, 3, 3, NONE, 0);
        step(st(1, 0, 0, 0, 0, 12, 1, 0, 1, 0, 0), 0, 0, 0, 0, NONE, 0); // c18 mc op
        step(st(1, 12, 0, 1, 0, 13, 1, 0, 0, 1, 0), 0, 0, 0, 0, HD, 0);  // branch ignored
        a = st(1, 12, 0, 1, 0, 13, 1, 0, 0, 0, 0);
        step(a, 0, 0, 0, 0, HD, 0);
        step(a, 0, 0, 0, 0, HD, 0);
        step(a, 1, 0, 1, 0, NONE, 0);
        step(st(1, 12, 13, 1, 1, 0, 0, 0, 0, 0, 0), 2, 1, 2, 1, NONE, 0);
        step(st(1, 0, 0, 0, 0, 14, 1, 0, 1, 0, 0), 0, 0, 0, 0, NONE, 0); // c24 mc op
        a = st(1, 0, 0, 0, 0, 15, 1, 0, 0, 0, 0);
        step(a, 0, 0, 0, 0, HD, 0);
        step(a, 0, 0, 0, 0, NONE, 1);                                    // c26 reset mid-hold
        step(st(1, 14, 0, 1, 0, 15, 1, 0, 0, 0, 0), 0, 0, 0, 0, NONE, 0);
        reset = 1'b1;
        step(st(1, 15, 14, 1, 1, 1, 1, 0, 0, 0, 0), 1, 0, 1, 0, NONE, 0);
        step(st(0, 1, 15, 1, 1, 0, 0, 0, 0, 0, 1), 1, 2, 1, 2, FL, 0);   // c29 irq flush
        done = 1'b1;
    end

    initial begin
        exp_t e;
        logic [17:0] act;
        logic [17:0] want;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            if (obs_vld) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: output sampled with no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    act = {bus0.fwd_sel_a, bus0.fwd_sel_b, bus1.fwd_sel_a, bus1.fwd_sel_b,
                           bus0.stall_pc, bus0.stall_dc, bus0.bubble_ex, bus0.flush_dc, bus0.mc_hold,
                           bus1.stall_pc, bus1.stall_dc, bus1.bubble_ex, bus1.flush_dc, bus1.mc_hold};
                    want = {e.a, e.b, e.za, e.zb, e.ctl, e.ctl};
                    if (act !== want) begin
                        n_fail++;
                        $display("FAIL c%0d: got fa=%0d fb=%0d za=%0d zb=%0d ctl=%b/%b, want fa=%0d fb=%0d za=%0d zb=%0d ctl=%b",
                                 e.id, act[17:16], act[15:14], act[13:12], act[11:10], act[9:5], act[4:0],
                                 e.a, e.b, e.za, e.zb, e.ctl);
                    end
                end
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: stimulus did not complete within cycle budget");
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d expectations never checked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined 16-bit core. It replaces the fixed stall-control and forwarding-select logic with one block. The block tracks in-flight destination registers through the EX, DM and WB stages, generates operand forwarding selects for the instruction in DC, and handles load-use stalls, multi-cycle EX operations, and branch or interrupt flushes. It sits beside the decode block and drives the program memory stall inputs and the register bank mux selects.

## Interface
Parameters:
- REG_AW, 5: register address width.
- MC_CYCLES, 4: number of cycles a multi-cycle op occupies EX; must be at least 2.
- ZERO_REG, 1: if 1, register 0 is never forwarded and never causes a hazard.

Ports:
- clk, in, 1: single clock. All state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- dc_valid, in, 1: the DC stage holds a real instruction.
- dc_ra / dc_rb, in, REG_AW: source register addresses.
- dc_use_a / dc_use_b, in, 1: the instruction actually reads RA / RB.
- dc_rw, in, REG_AW: destination register.
- dc_wr_en, in, 1: the instruction writes dc_rw.
- dc_is_load, in, 1: load; its data is available at the end of DM.
- dc_is_mc, in, 1: multi-cycle EX operation.
- ex_branch_taken, in, 1: a branch resolved taken in EX this cycle.
- irq_take, in, 1: an interrupt is accepted this cycle.
- fwd_sel_a / fwd_sel_b, out, 2: 0 = register file, 1 = ans_ex, 2 = ans_dm, 3 = ans_wb.
- stall_pc, out, 1: hold the PC.
- stall_dc, out, 1: hold the DC stage.
- bubble_ex, out, 1: insert a NOP into EX at the next edge.
- flush_dc, out, 1: squash the DC instruction.
- mc_hold, out, 1: EX holds its current multi-cycle op.

## Operation
- **Shadow registers.** Three shadow entries, EX, DM and WB, each holding {valid, rw, wr_en, is_load, is_mc}. There is also an mc_cnt counter of width clog2(MC_CYCLES).
- **Forwarding** (combinational). For each used source with a nonzero address (when ZERO_REG=1), match against the shadows in priority order EX > DM > WB. A shadow matches only if valid && wr_en && rw == src. No match, or source unused, gives select 0.
- **Load-use.** If the EX shadow is a load and matches a used DC source, assert stall_pc = stall_dc = bubble_ex = 1 for exactly one cycle. In the following cycle the load is in DM and fwd_sel = 2.
- **Multi-cycle.** When an is_mc instruction enters EX, load mc_cnt = MC_CYCLES-1.
  - While mc_cnt != 0: mc_hold = stall_pc = stall_dc = 1, the EX shadow holds, DM receives a bubble, WB advances, and mc_cnt decrements.
  - Forwarding from the held EX entry is suppressed; its result is not ready.
- **Flush.** ex_branch_taken or irq_take asserts flush_dc = bubble_ex = 1. The DC instruction is discarded and the EX shadow becomes invalid at the next edge. stall_pc = 0 so that the jump target loads.
- **Priority** (highest first): mc_hold, then flush, then load-use stall, then normal advance.
  - ex_branch_taken is ignored while mc_cnt != 0.
  - A flush masks any load-use stall in the same cycle.
- **Normal advance.** DC enters EX (valid = dc_valid && !flush), EX moves to DM, DM moves to WB, and WB is retired.

## Timing
- All outputs are combinational from the shadows and the dc_* inputs; there is zero-cycle decision latency. State updates on the clock edge.
- Load-use costs 1 stall cycle.
- A multi-cycle op costs MC_CYCLES-1 stall cycles.
- A flush costs 1 bubble.
- Reset, asserted asynchronously at any time including during a multi-cycle hold, sets:
  - all shadows invalid;
  - mc_cnt = 0;
  - outputs fwd_sel = 0, stall_pc = stall_dc = bubble_ex = flush_dc = mc_hold = 0.
- On release, the first edge with dc_valid = 1 loads EX normally.
- Back-to-back load-use on both operands: one stall only, not two.
- The same register written in EX and DM: EX wins (fwd = 1).

## Structure
- A shared core package holds the FWD_RF / FWD_EX / FWD_DM / FWD_WB constants (2 bits) and the shadow-entry struct typedef, reused by the register bank and decode blocks.
- One sub-module, pipe_fwd_match: a pure comparator that takes one source, its use bit and the three shadows and returns the select. It is instantiated twice, for A and B.

## Test plan
- EX = {wr_en, rw = 3}, DC reads RA = 3, RB = 3 -> fwd_sel_a = fwd_sel_b = 1, no stall.
- EX = load rw = 4, DC uses RB = 4 -> stall_pc = stall_dc = bubble_ex = 1 for 1 cycle; next cycle fwd_sel_b = 2, stalls 0.
- MC op with MC_CYCLES = 4 enters EX -> mc_hold = stall_pc = 1 for exactly 3 cycles, then the op advances to DM and the dependent DC read gets fwd = 2.
- ex_branch_taken = 1 in the same cycle as a load-use match -> flush_dc = 1, bubble_ex = 1, stall_pc = 0; next cycle the EX shadow is invalid.
- Writes to r0 in EX, DM and WB with DC reading r0 (ZERO_REG = 1) -> fwd_sel = 0, no stall; with ZERO_REG = 0 -> fwd = 1.
- reset driven low in the 2nd cycle of an MC hold -> all outputs 0 immediately and mc_cnt = 0; after release there is no residual stall.
